// File: rtl/prog_seq_pkg.sv
// Shared types for the programmable sequence repeater.
//   mode_e  : playback mode encoding as seen on the mode port
//   state_e : control FSM states
//   DIR_*   : ping-pong direction encoding
package prog_seq_pkg;

    typedef enum logic [1:0] {
        MODE_REPEAT   = 2'd0,
        MODE_ONESHOT  = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_RSVD     = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/seq_pattern_ram.sv
// DEPTH x DATA_W pattern register file, cleared by async reset.
//   clk, rst      : clock, async active-high reset (clears all entries)
//   we/waddr/wdata: single write port (caller filters illegal writes)
//   raddr/rdata   : combinational read port
module seq_pattern_ram #(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DEPTH-1:0][DATA_W-1:0] mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_sequence_repeater.sv
// Programmable sequence repeater: replays the first cfg_len pattern words
// over a valid/ready stream in REPEAT, ONESHOT or PINGPONG mode.
//   clk, rst            : clock, async active-high reset
//   cfg_we/addr/data    : pattern write port (accepted only while idle)
//   cfg_len, mode       : sequence length / playback mode, sampled at start
//   start, stop         : begin / abort playback
//   dout, dout_valid    : registered output word and its valid
//   dout_ready          : consumer accept
//   busy                : high while playing
//   done                : 1-cycle pulse after the last ONESHOT accept
//   cfg_err             : 1-cycle pulse on rejected start or write
module prog_sequence_repeater
    import prog_seq_pkg::*;
#(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [ADDR_W:0]   cfg_len,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic              stop,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    state_e              state_q, state_n;
    mode_e               mode_q, mode_n;
    logic [ADDR_W:0]     len_q, len_n, len_m1;
    logic [ADDR_W-1:0]   idx_q, idx_n, nxt, rd_addr;
    logic                dir_q, dir_n, nxt_dir, last;
    logic [DATA_W-1:0]   dout_q, dout_n, ram_rdata, rd_word;
    logic                done_n, err_n;
    logic                addr_ok, wr_ok, legal_start;

    // Out-of-range addresses only exist when DEPTH is not a power of two.
    if (DEPTH == (1 << ADDR_W)) begin : g_pow2
        assign addr_ok = 1'b1;
    end else begin : g_npow2
        assign addr_ok = ({1'b0, cfg_addr} < DEPTH_L);
    end

    assign busy        = (state_q == ST_RUN);
    assign dout_valid  = busy;
    assign dout        = dout_q;
    assign wr_ok       = cfg_we && !busy && addr_ok;
    assign legal_start = (cfg_len != '0) && (cfg_len <= DEPTH_L) &&
                         (mode != MODE_RSVD);

    // Index / direction successor for the current position.
    assign len_m1 = len_q - 1'b1;
    assign last   = ({1'b0, idx_q} == len_m1);

    always_comb begin
        nxt     = idx_q + 1'b1;
        nxt_dir = dir_q;
        case (mode_q)
            MODE_REPEAT: begin
                if (last) nxt = '0;
            end
            MODE_PINGPONG: begin
                if (len_q == 1) begin
                    nxt = '0;
                end else if (dir_q == DIR_UP) begin
                    nxt = idx_q + 1'b1;
                    if ({1'b0, nxt} == len_m1) nxt_dir = DIR_DOWN;
                end else begin
                    nxt = idx_q - 1'b1;
                    if (nxt == '0) nxt_dir = DIR_UP;
                end
            end
            default: nxt = idx_q + 1'b1;
        endcase
    end

    // Idle reads slot 0 for the first word; a same-cycle write to the slot
    // being read is forwarded so start sees freshly written data.
    assign rd_addr = busy ? nxt : '0;
    assign rd_word = (wr_ok && cfg_addr == rd_addr) ? cfg_data : ram_rdata;

    seq_pattern_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (wr_ok),
        .waddr(cfg_addr),
        .wdata(cfg_data),
        .raddr(rd_addr),
        .rdata(ram_rdata)
    );

    always_comb begin
        state_n = state_q;
        mode_n  = mode_q;
        len_n   = len_q;
        idx_n   = idx_q;
        dir_n   = dir_q;
        dout_n  = dout_q;
        done_n  = 1'b0;
        err_n   = cfg_we && (busy || !addr_ok);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (legal_start) begin
                        state_n = ST_RUN;
                        mode_n  = mode_e'(mode);
                        len_n   = cfg_len;
                        idx_n   = '0;
                        dir_n   = DIR_UP;
                        dout_n  = rd_word;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // stop wins over a same-cycle accept
                if (stop) begin
                    state_n = ST_IDLE;
                end else if (dout_ready) begin
                    if (mode_q == MODE_ONESHOT && last) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        idx_n  = nxt;
                        dir_n  = nxt_dir;
                        dout_n = rd_word;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_REPEAT;
            len_q   <= '0;
            idx_q   <= '0;
            dir_q   <= DIR_UP;
            dout_q  <= '0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state_q <= state_n;
            mode_q  <= mode_n;
            len_q   <= len_n;
            idx_q   <= idx_n;
            dir_q   <= dir_n;
            dout_q  <= dout_n;
            done    <= done_n;
            cfg_err <= err_n;
        end
    end

endmodule

// File: tb/tb_prog_sequence_repeater.sv
module tb_prog_sequence_repeater;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [2:0] cfg_data;
    logic [3:0] cfg_len;
    logic [1:0] mode;
    logic       start, stop;
    logic [2:0] dout;
    logic       dout_valid, dout_ready, busy, done, cfg_err;

    int vecs = 0;
    int miss = 0;

    prog_sequence_repeater #(.DATA_W(3), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_len   (cfg_len),
        .mode      (mode),
        .start     (start),
        .stop      (stop),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        vecs++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // advance one edge, then settle so outputs are sampled off the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        cfg_we = 1'b1; cfg_addr = 3'(a); cfg_data = 3'(d);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic go(input int len, input int m);
        cfg_len = 4'(len); mode = 2'(m); start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    int legacy[9] = '{1, 6, 5, 7, 3, 2, 4, 1, 6};
    int ppong[9]  = '{0, 1, 2, 3, 2, 1, 0, 1, 2};
    int os_dout[5] = '{5, 2, 2, 7, 7};

    initial begin
        rst = 1'b1; cfg_we = 0; cfg_addr = 0; cfg_data = 0; cfg_len = 0;
        mode = 0; start = 0; stop = 0; dout_ready = 0;
        step(); step();
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", cfg_err, 0);
        rst = 1'b0;
        step();

        // legacy 7-step pattern, REPEAT
        for (int i = 0; i < 7; i++) wr(i, legacy[i]);
        dout_ready = 1'b1;
        go(7, 0);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("rep_dout%0d", i), dout, legacy[i]);
            chk($sformatf("rep_valid%0d", i), dout_valid, 1);
            step();
        end
        halt();
        chk("rep_stop_busy", busy, 0);

        // ONESHOT with alternating ready
        wr(0, 5); wr(1, 2); wr(2, 7);
        go(3, 1);
        for (int k = 0; k < 5; k++) begin
            dout_ready = (k % 2 == 0);
            chk($sformatf("os_dout%0d", k), dout, os_dout[k]);
            chk($sformatf("os_nodone%0d", k), done, 0);
            step();
        end
        chk("os_done", done, 1);
        chk("os_valid", dout_valid, 0);
        chk("os_busy", busy, 0);
        chk("os_hold", dout, 7);
        step();
        chk("os_done_pulse", done, 0);

        // PINGPONG len 4
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) wr(i, i);
        go(4, 2);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("pp_dout%0d", i), dout, ppong[i]);
            step();
        end
        halt();
        // PINGPONG len 1
        wr(0, 5);
        go(1, 2);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("pp1_dout%0d", i), dout, 5);
            step();
        end
        halt();

        // illegal starts
        go(0, 0);
        chk("err_len0", cfg_err, 1);
        chk("err_len0_busy", busy, 0);
        step();
        chk("err_len0_pulse", cfg_err, 0);
        go(9, 0);
        chk("err_len9", cfg_err, 1);
        chk("err_len9_busy", busy, 0);
        go(4, 3);
        chk("err_mode3", cfg_err, 1);
        chk("err_mode3_busy", busy, 0);
        step();

        // write during RUN is dropped: mem[0]=5, mem[1]=1
        go(2, 0);
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 3'd6;
        step();
        cfg_we = 1'b0;
        chk("err_busy_wr", cfg_err, 1);
        halt();
        go(2, 0);
        chk("ram_keep0", dout, 5);
        step();
        chk("ram_keep1", dout, 1);
        halt();

        // stop + ready on the last ONESHOT word
        go(2, 1);
        step();
        chk("ss_dout", dout, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("ss_busy", busy, 0);
        chk("ss_valid", dout_valid, 0);
        chk("ss_nodone", done, 0);

        // start while busy is ignored without error
        go(2, 0);
        cfg_len = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("sb_err", cfg_err, 0);
        chk("sb_busy", busy, 1);
        chk("sb_dout", dout, 1);
        halt();

        // write and start in the same cycle
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 3'd3;
        go(2, 0);
        cfg_we = 1'b0;
        chk("ws_err", cfg_err, 0);
        chk("ws_dout", dout, 3);
        halt();

        // async reset mid-run
        go(2, 0);
        step();
        #2 rst = 1'b1;
        #1;
        chk("ar_dout", dout, 0);
        chk("ar_valid", dout_valid, 0);
        chk("ar_busy", busy, 0);
        #1 rst = 1'b0;
        go(2, 0);
        chk("ar_run0", dout, 0);
        step();
        chk("ar_run1", dout, 0);
        chk("ar_valid1", dout_valid, 1);
        halt();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
